tt_um_param_log_fpm: RTL
========================

# tt_um_param_log_fpm

Parametrised byte-serial floating-point multiplier for the TinyTapeout tile, successor to the fixed FP16 log-approximate multiplier. It supports any sign/exponent/mantissa split whose total width is a multiple of 8, and offers two mantissa modes: Mitchell log-approximate and exact-truncated. It handles zero, overflow and underflow explicitly, and uses valid/ready handshakes on both the input and output byte streams.

## Interface
- EW, 5: exponent field width (3..8); bias = 2^(EW-1)-1.
- MW, 10: mantissa fraction width (2..23); W = 1+EW+MW must be 8, 16, 24 or 32; NB = W/8.
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ena  input  1  tile enable; when low all registers hold.
- ui_in  input  8  operand data byte.
- uio_in  input  8  [0] in_valid, [1] out_ready, [2] mode (0 = Mitchell approx, 1 = exact truncated); [7:3] unused.
- uo_out  output  8  result byte.
- uio_out  output  8  [3] in_ready, [4] out_valid, [5] ovf, [6] unf, [7] zero; [2:0] = 0.
- uio_oe  output  8  constant 8'b1111_1000.

## Operation
- FSM states: LOAD, CALC, SEND. Reset state is LOAD.
- LOAD: in_ready = 1.
  - A byte is accepted when in_valid = 1 and ena = 1.
  - Byte order: A LSB first (NB bytes), then B LSB first (NB bytes); counter runs 0..2*NB-1.
  - mode is sampled on the last byte. Acceptance of the last byte moves to CALC.
- CALC: one cycle. Computes the result and flags into the result register, then moves to SEND.
- SEND: out_valid = 1; uo_out = result byte[idx], LSB first.
  - idx advances when out_ready = 1 and ena = 1.
  - Acceptance of byte NB-1 returns to LOAD with counters cleared.
- Fields: S = bit W-1, E = bits W-2..MW, F = bits MW-1..0. S_out = Sa ^ Sb.
- Zero: operand E = 0 (denormals flushed) → result {S_out, 0...}, zero = 1, ovf = unf = 0.
- Exponent field all-ones is an ordinary normal value; there is no Inf/NaN.
- Mitchell mode (mode 0):
  - s = Fa + Fb (MW+1 bits), c = s[MW]; F_out = s[MW-1:0].
- Exact mode (mode 1):
  - p = {1,Fa} * {1,Fb} (2MW+2 bits), c = p[2MW+1].
  - F_out = c ? p[2MW:MW+1] : p[2MW-1:MW], truncated toward zero.
- Exponent: e = Ea + Eb - bias + c, computed signed in EW+2 bits.
- Overflow: e > 2^EW-1 → result {S_out, all-ones E, all-ones F}, ovf = 1.
- Underflow: e ≤ 0 → result {S_out, 0...}, unf = 1.
- Flags are registered with the result in CALC. They are driven only while out_valid = 1 and are 0 otherwise.

## Timing
- Reset values: uo_out = 0, out_valid = 0, all flags = 0, in_ready = 1 in the cycle after the reset edge, byte counter = 0, result register = 0.
- in_ready and out_valid are decoded from the state register. uo_out is a mux of the result register, forced to 0 outside SEND.
- Latency: last input byte accepted at edge t → CALC during cycle t+1 → out_valid high from cycle t+2. Minimum operation is 2*NB + 1 + NB cycles.
- in_valid is ignored outside LOAD; out_ready is ignored outside SEND.
- Backpressure: with out_ready = 0, uo_out and flags hold indefinitely.
- ena = 0: state, counters and result are frozen; outputs keep their current values and no byte is accepted.
- rst_n low at any edge, mid-load or mid-send, discards the partial operation and returns to LOAD with counters cleared.
- There is no abort or pipelining; a new load begins only after the last result byte is accepted.

## Test plan
- FP16 defaults, mode 1: A = 0x3E00 (1.5), B = 0x3E00 → result 0x4080 (2.25), all flags 0. out_valid rises exactly 2 cycles after the 4th input byte.
- Same operands, mode 0 → 0x4000 (Mitchell 2.0), flags 0. Also 0xC000 × 0x4200, mode 1 → 0xC600 (-6.0).
- Special cases:
  - 0x7BFF × 0x7BFF → 0x7FFF with ovf = 1.
  - 0x0400 × 0x0400 → 0x0000 with unf = 1.
  - 0x8000 × 0x3C00 → 0x8000 with zero = 1.
- Handshakes:
  - Insert in_valid gaps and ena = 0 cycles during load → same result.
  - Hold out_ready = 0 for 5 cycles in SEND → uo_out stable; next byte appears only after out_ready = 1.
- Reset mid-load after 3 bytes, then a full 0x3C00 × 0x3C00 load → 0x3C00. No stale bytes are used.
- EW = 4, MW = 3 (NB = 1), mode 1:
  - 0x3C × 0x3C → 0x41.
  - 0x38 × 0x38 → 0x38.
  - Only 2 input bytes and 1 output byte per operation.

Source files
------------

// File: rtl/tt_um_param_log_fpm_if.sv
// TinyTapeout tile pins for the byte-serial FP multiplier, bundled so the
// tile and its driver share one connection point.
interface tt_um_param_log_fpm_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_param_log_fpm.sv
// Byte-serial FP multiplier with parametrised field split: loads A then B
// LSB first, multiplies in one cycle (Mitchell or exact-truncated), streams result.
module tt_um_param_log_fpm #(
  parameter int EW = 5,
  parameter int MW = 10
) (
  input logic clk,
  input logic rst_n,
  tt_um_param_log_fpm_if.slave bus
);
  localparam int W    = 1 + EW + MW;
  localparam int NB   = W / 8;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam logic [2:0] LAST_IN  = 3'(2 * NB - 1);
  localparam logic [2:0] LAST_OUT = 3'(NB - 1);

  typedef enum logic [1:0] {LOAD, CALC, SEND} state_t;

  state_t         state;
  logic [2:0]     cnt;
  logic [2*W-1:0] opnd;
  logic           mode_r;
  logic [W-1:0]   res, res_n;
  logic           ovf, unf, zero, ovf_n, unf_n, zero_n;

  logic in_valid, out_ready, mode, in_load, in_send;
  assign in_valid  = bus.uio_in[0];
  assign out_ready = bus.uio_in[1];
  assign mode      = bus.uio_in[2];
  assign in_load   = (state == LOAD);
  assign in_send   = (state == SEND);

  logic [W-1:0]      a, b;
  logic              so;
  logic [EW-1:0]     ea, eb;
  logic [MW-1:0]     fa, fb, fo;
  logic [MW:0]       sum;
  logic [2*MW+1:0]   prod;
  logic              c;
  logic signed [EW+1:0] e;

  always_comb begin
    a    = opnd[W-1:0];
    b    = opnd[2*W-1:W];
    so   = a[W-1] ^ b[W-1];
    ea   = a[W-2:MW];
    eb   = b[W-2:MW];
    fa   = a[MW-1:0];
    fb   = b[MW-1:0];
    sum  = {1'b0, fa} + {1'b0, fb};
    prod = {{MW{1'b0}}, 1'b1, fa} * {{MW{1'b0}}, 1'b1, fb};
    if (mode_r) begin
      c  = prod[2*MW+1];
      fo = c ? prod[2*MW:MW+1] : prod[2*MW-1:MW];
    end else begin
      c  = sum[MW];
      fo = sum[MW-1:0];
    end
    // Two guard bits keep the biased sum signed and overflow-free for every EW.
    e = $signed({2'b00, ea}) + $signed({2'b00, eb})
      - $signed((EW+2)'(BIAS)) + $signed((EW+2)'(c));
    res_n  = {so, {(W-1){1'b0}}};
    ovf_n  = 1'b0;
    unf_n  = 1'b0;
    zero_n = 1'b0;
    if (ea == '0 || eb == '0) zero_n = 1'b1;
    else if (e[EW+1] || e == '0) unf_n = 1'b1;
    else if (e[EW]) begin
      ovf_n = 1'b1;
      res_n = {so, {(W-1){1'b1}}};
    end else res_n = {so, e[EW-1:0], fo};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= LOAD;
      cnt    <= '0;
      opnd   <= '0;
      mode_r <= 1'b0;
      res    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      zero   <= 1'b0;
    end else if (bus.ena) begin
      unique case (state)
        LOAD: if (in_valid) begin
          for (int i = 0; i < 2 * NB; i++)
            if (cnt == 3'(i)) opnd[i*8 +: 8] <= bus.ui_in;
          if (cnt == LAST_IN) begin
            mode_r <= mode;
            cnt    <= '0;
            state  <= CALC;
          end else cnt <= cnt + 3'd1;
        end
        CALC: begin
          res   <= res_n;
          ovf   <= ovf_n;
          unf   <= unf_n;
          zero  <= zero_n;
          state <= SEND;
        end
        SEND: if (out_ready) begin
          if (cnt == LAST_OUT) begin
            cnt   <= '0;
            state <= LOAD;
          end else cnt <= cnt + 3'd1;
        end
        default: state <= LOAD;
      endcase
    end
  end

  logic [7:0] out_byte;
  always_comb begin
    out_byte = '0;
    for (int i = 0; i < NB; i++)
      if (in_send && cnt == 3'(i)) out_byte = res[i*8 +: 8];
  end

  assign bus.uo_out  = out_byte;
  assign bus.uio_out = {zero & in_send, unf & in_send, ovf & in_send,
                        in_send, in_load, 3'b000};
  assign bus.uio_oe  = 8'b1111_1000;

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.uio_in[7:3], prod[MW-1:0]};
endmodule
